// File: rtl/sbtel_pkg.sv
// Shared types for the registered MEM stage.
//   ID_MEM           : decoded operands/control carried ID -> MEM -> EX
//   MEMOP_*          : memory operation codes on id_mem_op (2'b11 reserved, acts as none)
//   memstage_state_e : MEM-stage sequencing FSM
package sbtel_pkg;
  localparam int XLEN = 64;

  localparam logic [1:0] MEMOP_NONE  = 2'b00;
  localparam logic [1:0] MEMOP_LOAD  = 2'b01;
  localparam logic [1:0] MEMOP_STORE = 2'b10;

  typedef struct packed {
    logic [XLEN-1:0] pc_contents;
    logic [XLEN-1:0] data_regA;   // store data
    logic [XLEN-1:0] data_regB;   // address base; becomes load data on loads
    logic [XLEN-1:0] data_disp;   // address displacement
    logic [4:0]      rd;
    logic            sim_end;
  } ID_MEM;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_LD_REQ,
    MS_LD_WAIT,
    MS_OUT
  } memstage_state_e;
endpackage

// File: rtl/mod_store_queue.sv
// Circular store queue with youngest-match address lookup.
//   clk, reset           : clock, synchronous active-high reset
//   enq, enq_addr/data   : push at tail
//   deq                  : pop head (caller guarantees non-empty)
//   head_addr/head_data  : oldest entry
//   full, empty, count   : occupancy
//   lk_addr -> lk_hit/lk_data : exact-address match, youngest entry wins
module mod_store_queue #(
  parameter  int ADDR_W = 64,
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 4,
  localparam int PW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enq,
  input  logic [ADDR_W-1:0] enq_addr,
  input  logic [DATA_W-1:0] enq_data,
  input  logic              deq,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty,
  output logic [PW:0]       count,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              lk_hit,
  output logic [DATA_W-1:0] lk_data
);
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [PW-1:0] head_q, tail_q, idx;
  logic [PW:0]   count_q;

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= enq_addr;
      data_q[tail_q] <= enq_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) tail_q <= tail_q + PW'(1);
      if (deq) head_q <= head_q + PW'(1);
      case ({enq, deq})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: ;
      endcase
    end
  end

  // Walk oldest -> youngest so the last match seen is the youngest store.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    idx     = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (((PW+1)'(i) < count_q) && (addr_q[idx] == lk_addr)) begin
        lk_hit  = 1'b1;
        lk_data = data_q[idx];
      end
    end
  end

  assign head_addr = addr_q[head_q];
  assign head_data = data_q[head_q];
  assign count     = count_q;
  assign full      = (count_q == (PW+1)'(DEPTH));
  assign empty     = (count_q == '0);
endmodule

// File: rtl/mod_memstage_sq.sv
// Registered MEM stage with store queue and store-to-load forwarding.
//   clk, reset               : clock, synchronous active-high reset
//   id_valid/id_ready, idmem, id_mem_op : entry from ID_MEM register
//   ex_valid/ex_ready, memex : entry to EX (data_regB = load data on loads)
//   dreq_* / dresp_*         : single data port, one request outstanding
//   stq_count, stq_empty     : store-queue occupancy
module mod_memstage_sq
  import sbtel_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int STQ_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       id_valid,
  output logic                       id_ready,
  input  ID_MEM                      idmem,
  input  logic [1:0]                 id_mem_op,
  output logic                       ex_valid,
  input  logic                       ex_ready,
  output ID_MEM                      memex,
  output logic                       dreq_valid,
  input  logic                       dreq_ready,
  output logic                       dreq_we,
  output logic [ADDR_W-1:0]          dreq_addr,
  output logic [DATA_W-1:0]          dreq_wdata,
  input  logic                       dresp_valid,
  input  logic [DATA_W-1:0]          dresp_data,
  output logic [$clog2(STQ_DEPTH):0] stq_count,
  output logic                       stq_empty
);
  memstage_state_e   state_q, state_d;
  ID_MEM             memex_q;
  logic [ADDR_W-1:0] ld_addr_q, ea, head_addr;
  logic [DATA_W-1:0] head_data, hit_data;
  logic [1:0]        op;
  logic is_ld, is_st, sq_full, sq_empty, sq_hit;
  logic st_hold_q, ld_busy, st_sel, ld_sel, ld_hs, deq, enq;
  logic slot_free, accept, ld_miss;

  assign ea = ADDR_W'(idmem.data_regB + idmem.data_disp);

  // sim_end and the reserved code both pass through as a plain none op.
  always_comb begin
    op = id_mem_op;
    if (idmem.sim_end || id_mem_op == 2'b11) op = MEMOP_NONE;
  end
  assign is_ld = (op == MEMOP_LOAD);
  assign is_st = (op == MEMOP_STORE);

  // Port mux. A store already presented but not yet taken keeps the port
  // (st_hold_q) so dreq_* stay stable; otherwise a pending load miss wins.
  assign ld_busy    = (state_q == MS_LD_REQ) || (state_q == MS_LD_WAIT);
  assign st_sel     = st_hold_q || (!ld_busy && !sq_empty);
  assign ld_sel     = !st_sel && (state_q == MS_LD_REQ);
  assign dreq_valid = st_sel || ld_sel;
  assign dreq_we    = st_sel;
  assign dreq_addr  = st_sel ? head_addr : (ld_sel ? ld_addr_q : '0);
  assign dreq_wdata = st_sel ? head_data : '0;
  assign deq        = st_sel && dreq_ready;
  assign ld_hs      = ld_sel && dreq_ready;

  // A full queue still takes a store when its head drains this cycle.
  assign slot_free = (state_q == MS_IDLE) || ((state_q == MS_OUT) && ex_ready);
  assign id_ready  = slot_free && !(is_st && sq_full && !deq)
                               && !(idmem.sim_end && !sq_empty);
  assign accept    = id_valid && id_ready;
  assign enq       = accept && is_st;
  assign ld_miss   = is_ld && !sq_hit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      MS_IDLE:    if (accept) state_d = ld_miss ? MS_LD_REQ : MS_OUT;
      MS_LD_REQ:  if (ld_hs) state_d = MS_LD_WAIT;
      MS_LD_WAIT: if (dresp_valid) state_d = MS_OUT;
      MS_OUT: begin
        if (accept)        state_d = ld_miss ? MS_LD_REQ : MS_OUT;
        else if (ex_ready) state_d = MS_IDLE;
      end
      default:    state_d = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MS_IDLE;
      memex_q   <= '0;
      ld_addr_q <= '0;
      st_hold_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      st_hold_q <= st_sel && !dreq_ready;
      if (accept) begin
        memex_q <= idmem;
        if (is_ld && sq_hit) memex_q.data_regB <= XLEN'(hit_data);
        if (ld_miss) ld_addr_q <= ea;
      end else if ((state_q == MS_LD_WAIT) && dresp_valid) begin
        memex_q.data_regB <= XLEN'(dresp_data);
      end
    end
  end

  assign ex_valid = (state_q == MS_OUT);
  assign memex    = memex_q;

  mod_store_queue #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (STQ_DEPTH)
  ) u_stq (
    .clk       (clk),
    .reset     (reset),
    .enq       (enq),
    .enq_addr  (ea),
    .enq_data  (DATA_W'(idmem.data_regA)),
    .deq       (deq),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (sq_full),
    .empty     (sq_empty),
    .count     (stq_count),
    .lk_addr   (ea),
    .lk_hit    (sq_hit),
    .lk_data   (hit_data)
  );

  assign stq_empty = sq_empty;
endmodule

// File: tb/tb_mod_memstage_sq.sv
// Bench for mod_memstage_sq: directed scenarios plus a randomized run, all
// checked against a sequential-memory reference model and a memory responder.
module tb_mod_memstage_sq;
  import sbtel_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0, id_ready;
  ID_MEM       idmem = '0;
  logic [1:0]  id_mem_op = 2'b00;
  logic        ex_valid, ex_ready = 1'b1;
  ID_MEM       memex;
  logic        dreq_valid, dreq_ready = 1'b0, dreq_we;
  logic [63:0] dreq_addr, dreq_wdata;
  logic        dresp_valid = 1'b0;
  logic [63:0] dresp_data = '0;
  logic [2:0]  stq_count;
  logic        stq_empty;

  always #5 clk = ~clk;

  mod_memstage_sq #(.ADDR_W(64), .DATA_W(64), .STQ_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_ready(id_ready), .idmem(idmem), .id_mem_op(id_mem_op),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .memex(memex),
    .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_we(dreq_we),
    .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata),
    .dresp_valid(dresp_valid), .dresp_data(dresp_data),
    .stq_count(stq_count), .stq_empty(stq_empty)
  );

  typedef struct { logic [63:0] addr; logic [63:0] data; } st_t;

  int n_chk = 0, n_err = 0, cyc = 0, acc_cyc = 0;
  bit acc_flag = 0, have_pend = 0, rst_req = 1, ld_busy = 0;
  int exr_mode = 1, drdy_mode = 0, lat_mode = -1, resp_cnt = -1, resp_fire_cyc = -1;
  logic [63:0] resp_data = '0;
  ID_MEM pend_ent = '0;
  logic [1:0] pend_op = 2'b00;

  ID_MEM       exp_q[$];
  st_t         st_q[$];
  logic [63:0] ld_q[$];
  logic [63:0] mem_img [logic [63:0]];
  logic [63:0] arch    [logic [63:0]];

  bit prev_ex_stall = 0, prev_dq_stall = 0;
  ID_MEM prev_memex;
  logic [128:0] prev_dq;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] dflt(input logic [63:0] a);
    return a ^ 64'hA5A5_5A5A_0F0F_F0F0;
  endfunction

  function automatic logic [63:0] rd_mem(input logic [63:0] a);
    return mem_img.exists(a) ? mem_img[a] : dflt(a);
  endfunction

  function automatic logic [63:0] rd_arch(input logic [63:0] a);
    return arch.exists(a) ? arch[a] : dflt(a);
  endfunction

  function automatic ID_MEM mk(input logic [63:0] pc, input logic [63:0] ra,
                               input logic [63:0] rb, input logic [63:0] dp, input bit se);
    ID_MEM e;
    e = '0;
    e.pc_contents = pc; e.data_regA = ra; e.data_regB = rb; e.data_disp = dp;
    e.rd = pc[6:2]; e.sim_end = se;
    return e;
  endfunction

  // Reference: program-order memory semantics. Expected output per accepted
  // entry; a load misses exactly when no store to its address is still pending.
  task automatic observe();
    ID_MEM e;
    logic [1:0] op;
    logic [63:0] ea;
    bit hit;
    st_t s;
    cyc++;
    acc_flag = 0;
    if (reset) begin prev_ex_stall = 0; prev_dq_stall = 0; return; end
    if (prev_ex_stall) begin
      chk("ex_hold_valid", ex_valid, 1'b1);
      chk("ex_hold_memex", memex, prev_memex);
    end
    if (prev_dq_stall) chk("dreq_hold", {dreq_valid, dreq_we, dreq_addr, dreq_wdata}, {1'b1, prev_dq});
    chk("stq_count", stq_count, st_q.size());
    chk("stq_empty", stq_empty, st_q.size() == 0);
    chk("one_outstanding", ld_busy && dreq_valid, 1'b0);
    if (id_valid && id_ready) begin
      e = idmem; op = id_mem_op;
      if (idmem.sim_end || op == 2'b11) op = 2'b00;
      ea = idmem.data_regB + idmem.data_disp;
      if (op == 2'b10) begin
        st_q.push_back('{ea, idmem.data_regA});
        arch[ea] = idmem.data_regA;
      end else if (op == 2'b01) begin
        hit = 0;
        foreach (st_q[i]) if (st_q[i].addr == ea) hit = 1;
        e.data_regB = rd_arch(ea);
        if (!hit) ld_q.push_back(ea);
      end
      exp_q.push_back(e);
      have_pend = 0; acc_flag = 1; acc_cyc = cyc;
    end
    if (dreq_valid && dreq_ready) begin
      if (dreq_we) begin
        if (st_q.size() == 0) chk("unexpected_store", 1'b1, 1'b0);
        else begin
          s = st_q.pop_front();
          chk("st_addr", dreq_addr, s.addr);
          chk("st_data", dreq_wdata, s.data);
          mem_img[dreq_addr] = dreq_wdata;
        end
      end else begin
        if (ld_q.size() == 0) chk("unexpected_load", 1'b1, 1'b0);
        else chk("ld_addr", dreq_addr, ld_q.pop_front());
        resp_cnt  = (lat_mode >= 0) ? lat_mode : $urandom_range(0, 3);
        resp_data = rd_mem(dreq_addr);
        ld_busy   = 1;
      end
    end
    if (ex_valid && ex_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", 1'b1, 1'b0);
      else chk("memex", memex, exp_q.pop_front());
    end
    prev_ex_stall = ex_valid && !ex_ready;
    prev_memex    = memex;
    prev_dq_stall = dreq_valid && !dreq_ready;
    prev_dq       = {dreq_we, dreq_addr, dreq_wdata};
  endtask

  // Drive just after the rising edge, observe at the falling edge.
  task automatic tick();
    @(posedge clk); #1;
    reset      = rst_req;
    id_valid   = have_pend && !rst_req;
    idmem      = pend_ent;
    id_mem_op  = pend_op;
    ex_ready   = (exr_mode == 2) ? ($urandom_range(0, 3) != 0) : (exr_mode == 1);
    dreq_ready = (drdy_mode == 2) ? ($urandom_range(0, 2) != 0) : (drdy_mode == 1);
    dresp_valid = 1'b0;
    if (resp_cnt == 0) begin
      dresp_valid = 1'b1; dresp_data = resp_data;
      ld_busy = 0; resp_cnt = -1; resp_fire_cyc = cyc + 1;
    end else if (resp_cnt > 0) resp_cnt--;
    @(negedge clk);
    observe();
  endtask

  task automatic pend_set(input ID_MEM e, input logic [1:0] op);
    pend_ent = e; pend_op = op; have_pend = 1;
  endtask

  task automatic send(input ID_MEM e, input logic [1:0] op);
    pend_set(e, op);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (acc_flag) return;
    end
    chk("accept_timeout", 1'b1, 1'b0);
    have_pend = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && st_q.size() == 0 && ld_q.size() == 0 &&
          !ld_busy && !have_pend && !ex_valid) return;
      tick();
    end
    chk("drain_timeout", 1'b1, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst_req = 1; have_pend = 0;
    exp_q.delete(); st_q.delete(); ld_q.delete();
    ld_busy = 0; arch = mem_img;
    repeat (n) tick();
    rst_req = 0;
    tick();
  endtask

  initial begin
    ID_MEM e, e2;
    int t0, rel_cyc, nacc;
    logic [63:0] ad, dp;

    do_reset(2);
    chk("rst_ex_valid", ex_valid, 1'b0);
    chk("rst_dreq_valid", dreq_valid, 1'b0);
    chk("rst_dreq_we", dreq_we, 1'b0);
    chk("rst_stq_count", stq_count, 3'd0);
    chk("rst_stq_empty", stq_empty, 1'b1);
    chk("rst_memex", memex, '0);
    chk("rst_dreq_addr", {dreq_addr, dreq_wdata}, '0);
    chk("rst_id_ready", id_ready, 1'b1);

    // none op passes through unchanged one cycle later
    exr_mode = 1; drdy_mode = 1; lat_mode = 2;
    e = mk(64'h1000, 64'h11, 64'h22, 64'h33, 0);
    send(e, MEMOP_NONE);
    tick();
    chk("none_ex_valid", ex_valid, 1'b1);
    chk("none_memex", memex, e);
    chk("none_no_dreq", dreq_valid, 1'b0);
    wait_idle();

    // load miss latency and address
    mem_img[64'h2010] = 64'hDEADBEEF; arch[64'h2010] = 64'hDEADBEEF;
    send(mk(64'h1004, 0, 64'h2000, 64'h10, 0), MEMOP_LOAD);
    t0 = acc_cyc;
    tick();
    chk("ld_req_valid", dreq_valid && !dreq_we, 1'b1);
    chk("ld_req_addr", dreq_addr, 64'h2010);
    for (int i = 0; i < 20 && !ex_valid; i++) tick();
    chk("ld_latency", cyc - t0, 5);
    chk("ld_data", memex.data_regB, 64'hDEADBEEF);
    wait_idle();

    // store-to-load forwarding from youngest entry
    drdy_mode = 0;
    send(mk(64'h1008, 64'h55, 64'h3000, 0, 0), MEMOP_STORE);
    send(mk(64'h100C, 64'h66, 64'h3000, 0, 0), MEMOP_STORE);
    send(mk(64'h1010, 0, 64'h2FF0, 64'h10, 0), MEMOP_LOAD);
    tick();
    chk("hit_ex_valid", ex_valid, 1'b1);
    chk("hit_data", memex.data_regB, 64'h66);
    chk("hit_no_ldreq", dreq_valid && !dreq_we, 1'b0);
    drdy_mode = 1;
    wait_idle();

    // full queue back-pressure, accept on first drain cycle
    drdy_mode = 0;
    for (int i = 0; i < 4; i++)
      send(mk(64'h1100 + 4*i, 64'hA0 + i, 64'h5000 + 8*i, 0, 0), MEMOP_STORE);
    pend_set(mk(64'h1110, 64'hA4, 64'h5020, 0, 0), MEMOP_STORE);
    repeat (3) begin
      tick();
      chk("full_id_ready", id_ready, 1'b0);
    end
    chk("full_count", stq_count, 3'd4);
    drdy_mode = 1;
    tick();
    chk("full_accept_on_drain", acc_flag, 1'b1);
    wait_idle();

    // sim_end waits for the store queue to empty
    drdy_mode = 0;
    send(mk(64'h1200, 64'h77, 64'h6000, 0, 0), MEMOP_STORE);
    send(mk(64'h1204, 64'h88, 64'h6008, 0, 0), MEMOP_STORE);
    pend_set(mk(64'h1208, 0, 0, 0, 1), MEMOP_NONE);
    repeat (3) begin
      tick();
      chk("simend_blocked", id_ready, 1'b0);
    end
    drdy_mode = 1;
    for (int i = 0; i < 20 && !acc_flag; i++) tick();
    chk("simend_accept", acc_flag, 1'b1);
    chk("simend_q_empty", stq_empty, 1'b1);
    tick();
    chk("simend_out", ex_valid && memex.sim_end, 1'b1);
    wait_idle();

    // reset while waiting for load data; late response ignored
    lat_mode = 5;
    send(mk(64'h1300, 0, 64'h7000, 0, 0), MEMOP_LOAD);
    tick(); tick();
    do_reset(2);
    rel_cyc = cyc;
    repeat (4) begin
      tick();
      chk("rst_late_ex_valid", ex_valid, 1'b0);
    end
    chk("late_resp_driven", resp_fire_cyc > rel_cyc, 1'b1);
    chk("rst_late_memex", memex, '0);
    chk("rst_late_dreq", {dreq_valid, dreq_we, dreq_addr}, '0);
    chk("rst_late_count", stq_count, 3'd0);
    lat_mode = 1;

    // address wrap
    send(mk(64'h1400, 0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h10, 0), MEMOP_LOAD);
    tick();
    chk("wrap_addr", dreq_addr, 64'h8);
    wait_idle();

    // EX back-pressure holds output
    exr_mode = 0;
    e = mk(64'h1500, 64'h1, 64'h2, 64'h3, 0);
    send(e, MEMOP_NONE);
    repeat (3) begin
      tick();
      chk("stall_ex_valid", ex_valid, 1'b1);
      chk("stall_id_ready", id_ready, 1'b0);
      chk("stall_memex", memex, e);
    end
    exr_mode = 1;
    e2 = mk(64'h1504, 64'h4, 64'h5, 64'h6, 0);
    pend_set(e2, MEMOP_NONE);
    tick();
    chk("stall_release_accept", acc_flag, 1'b1);
    tick();
    chk("stall_next_memex", memex, e2);
    wait_idle();

    // randomized traffic
    exr_mode = 2; drdy_mode = 2; lat_mode = -1; nacc = 0;
    for (int c = 0; c < 20000 && nacc < 300; c++) begin
      if (!have_pend && $urandom_range(0, 3) != 0) begin
        ad = 64'h4000 + 64'($urandom_range(0, 7)) * 8;
        dp = 64'($urandom_range(0, 63)) * 8 - 64'h100;
        pend_set(mk({32'h0, $urandom}, {$urandom, $urandom}, ad - dp, dp,
                    $urandom_range(0, 24) == 0), 2'($urandom_range(0, 3)));
      end
      tick();
      if (acc_flag) nacc++;
    end
    chk("rand_progress", nacc, 300);
    exr_mode = 1; drdy_mode = 1;
    wait_idle();
    chk("final_out_q", exp_q.size(), 0);
    chk("final_st_q", st_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
